// File: rtl/acc_mem_arbiter_if.sv
// Bundle of CPU, accelerator and data-memory signals arbitrated by acc_mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface acc_mem_arbiter_if #(
  parameter int NUM_ACC    = 2,
  parameter int ADDR_SIZE  = 16,
  parameter int WDATA_SIZE = 32,
  parameter int LINE_SIZE  = 512
);
  logic                          cpu_en;
  logic                          cpu_wr;
  logic [ADDR_SIZE-1:0]          cpu_addr;
  logic [WDATA_SIZE-1:0]         cpu_wdata;
  logic                          cpu_stall;

  logic [NUM_ACC-1:0]            acc_rd_en;
  logic [NUM_ACC*ADDR_SIZE-1:0]  acc_rd_addr;
  logic [NUM_ACC-1:0]            acc_wr_en;
  logic [NUM_ACC*ADDR_SIZE-1:0]  acc_wr_addr;
  logic [NUM_ACC*WDATA_SIZE-1:0] acc_wr_data;
  logic [NUM_ACC-1:0]            acc_rd_data_valid;
  logic [LINE_SIZE-1:0]          acc_rd_data;
  logic [NUM_ACC-1:0]            acc_wr_done;

  logic                          mem_en;
  logic                          mem_wr;
  logic [ADDR_SIZE-1:0]          mem_addr;
  logic [WDATA_SIZE-1:0]         mem_wdata;
  logic [LINE_SIZE-1:0]          mem_rdata;

  modport slave (
    input  cpu_en, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_stall,
    input  acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data,
    output acc_rd_data_valid, acc_rd_data, acc_wr_done,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_en, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_stall,
    output acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data,
    input  acc_rd_data_valid, acc_rd_data, acc_wr_done,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/acc_mem_arbiter.sv
// Shares one single-port data memory between a CPU (priority) and NUM_ACC accelerators
// (round-robin), with a starvation counter that forces an accelerator through.
module acc_mem_arbiter #(
  parameter int NUM_ACC      = 2,
  parameter int STARVE_LIMIT = 16,
  parameter int ADDR_SIZE    = 16,
  parameter int WDATA_SIZE   = 32,
  parameter int LINE_SIZE    = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  acc_mem_arbiter_if.slave  bus
);
  localparam int IW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_ptr;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_op;

  logic [NUM_ACC-1:0]    w_req;
  logic                  w_pend;
  logic                  w_force;
  logic                  w_issue;
  logic [IW:0]           w_pick;
  logic [IW-1:0]         w_gnt_idx;
  logic [IW-1:0]         w_ptr_nxt;
  logic                  w_op;
  logic [ADDR_SIZE-1:0]  w_acc_addr;
  logic [WDATA_SIZE-1:0] w_acc_wdata;
  logic [LINE_SIZE-1:0]  w_line;

  // Result MSB flags a hit; lowest rotation offset from ptr wins.
  function automatic logic [IW:0] rr_pick(input logic [NUM_ACC-1:0] req,
                                          input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = NUM_ACC - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_ACC) j = j - NUM_ACC;
      if (req[j]) res = {1'b1, j[IW-1:0]};
    end
    return res;
  endfunction

  assign w_req     = bus.acc_rd_en | bus.acc_wr_en;
  assign w_pend    = |w_req;
  assign w_pick    = rr_pick(w_req, r_ptr);
  assign w_gnt_idx = w_pick[IW-1:0];
  assign w_ptr_nxt = (w_gnt_idx == IW'(NUM_ACC - 1)) ? '0 : w_gnt_idx + 1'b1;

  assign w_force = (r_state == S_IDLE) && w_pend && (r_cnt == CW'(STARVE_LIMIT));
  assign w_issue = (r_state == S_IDLE) && w_pend && (!bus.cpu_en || w_force);

  // Read beats write inside one requester; op encodes mem_wr.
  assign w_op        = ~bus.acc_rd_en[w_gnt_idx];
  assign w_acc_addr  = w_op ? bus.acc_wr_addr[int'(w_gnt_idx)*ADDR_SIZE +: ADDR_SIZE]
                            : bus.acc_rd_addr[int'(w_gnt_idx)*ADDR_SIZE +: ADDR_SIZE];
  assign w_acc_wdata = bus.acc_wr_data[int'(w_gnt_idx)*WDATA_SIZE +: WDATA_SIZE];

  assign w_line          = bus.mem_rdata;
  assign bus.acc_rd_data = w_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt           = r_state;
    bus.mem_en            = 1'b0;
    bus.mem_wr            = 1'b0;
    bus.mem_addr          = '0;
    bus.mem_wdata         = '0;
    bus.cpu_stall         = 1'b0;
    bus.acc_rd_data_valid = '0;
    bus.acc_wr_done       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt   = S_RESP;
          bus.mem_en    = 1'b1;
          bus.mem_wr    = w_op;
          bus.mem_addr  = w_acc_addr;
          bus.mem_wdata = w_acc_wdata;
          bus.cpu_stall = w_force;
        end else if (bus.cpu_en) begin
          bus.mem_en    = 1'b1;
          bus.mem_wr    = bus.cpu_wr;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_wdata = bus.cpu_wdata;
        end
      end
      S_RESP: begin
        // Memory port is free here, so the CPU may use it alongside the acknowledge.
        w_state_nxt = S_IDLE;
        if (r_op) bus.acc_wr_done[r_idx]       = 1'b1;
        else      bus.acc_rd_data_valid[r_idx] = 1'b1;
        if (bus.cpu_en) begin
          bus.mem_en    = 1'b1;
          bus.mem_wr    = bus.cpu_wr;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_wdata = bus.cpu_wdata;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!rst_n) begin
      bus.mem_en            = 1'b0;
      bus.mem_wr            = 1'b0;
      bus.mem_addr          = '0;
      bus.mem_wdata         = '0;
      bus.cpu_stall         = 1'b0;
      bus.acc_rd_data_valid = '0;
      bus.acc_wr_done       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_idx <= '0;
      r_op  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_ptr <= w_ptr_nxt;
        r_idx <= w_gnt_idx;
        r_op  <= w_op;
        r_cnt <= '0;
      end else if (!w_pend) begin
        r_cnt <= '0;
      end else if ((r_state == S_IDLE) && bus.cpu_en && (r_cnt != CW'(STARVE_LIMIT))) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Bench for acc_mem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration rules.
module tb_acc_mem_arbiter;
  localparam int N   = 2;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LW  = 512;
  localparam int LIM = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  acc_mem_arbiter_if #(.NUM_ACC(N), .ADDR_SIZE(AW), .WDATA_SIZE(DW), .LINE_SIZE(LW)) bus();

  acc_mem_arbiter #(.NUM_ACC(N), .STARVE_LIMIT(LIM), .ADDR_SIZE(AW),
                    .WDATA_SIZE(DW), .LINE_SIZE(LW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {16{a, a ^ 16'hA5A5}};
  endfunction

  // Memory with one-cycle read latency; line contents derived from the address.
  always @(posedge clk)
    if (bus.mem_en && !bus.mem_wr) bus.mem_rdata <= line_of(bus.mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus.cpu_en      = 1'b0;
    bus.cpu_wr      = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = '0;
    bus.acc_rd_en   = '0;
    bus.acc_rd_addr = '0;
    bus.acc_wr_en   = '0;
    bus.acc_wr_addr = '0;
    bus.acc_wr_data = '0;
  endtask

  task automatic do_reset();
    init_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    init_inputs();
    #2;
    bus.cpu_en    = 1'b1;
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 16'h1234;
    bus.cpu_wdata = 32'hDEADBEEF;
    bus.acc_rd_en = '1;
    bus.acc_wr_en = '1;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.cpu_stall,
         bus.acc_rd_data_valid, bus.acc_wr_done} !== 54'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got en=%b wr=%b addr=%h wdata=%h stall=%b vld=%b done=%b, want all 0",
               bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.cpu_stall,
               bus.acc_rd_data_valid, bus.acc_wr_done);
    end
    n_cmp++;
    if (bus.acc_rd_data !== bus.mem_rdata) begin
      n_bad++;
      $display("FAIL reset_rd_data: acc_rd_data differs from mem_rdata");
    end
    tick();
    init_inputs();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.cpu_stall, bus.acc_rd_data_valid, bus.acc_wr_done} !== 6'd0) begin
      n_bad++;
      $display("FAIL idle_quiet: got en=%b stall=%b vld=%b done=%b, want 0",
               bus.mem_en, bus.cpu_stall, bus.acc_rd_data_valid, bus.acc_wr_done);
    end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.acc_rd_en = 2'b01;
    bus.acc_rd_addr[0 +: AW] = 16'h1008;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.cpu_stall, bus.acc_rd_data_valid, bus.acc_wr_done}
        !== {1'b1, 1'b0, 16'h1008, 1'b0, 2'b00, 2'b00}) begin
      n_bad++;
      $display("FAIL rd_issue: got en=%b wr=%b addr=%h stall=%b vld=%b, want 1 0 1008 0 00",
               bus.mem_en, bus.mem_wr, bus.mem_addr, bus.cpu_stall, bus.acc_rd_data_valid);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.acc_rd_data_valid, bus.acc_wr_done} !== {1'b0, 2'b01, 2'b00}) begin
      n_bad++;
      $display("FAIL rd_resp: got en=%b vld=%b done=%b, want 0 01 00",
               bus.mem_en, bus.acc_rd_data_valid, bus.acc_wr_done);
    end
    n_cmp++;
    if (bus.acc_rd_data !== line_of(16'h1008)) begin
      n_bad++;
      $display("FAIL rd_line: got %h want %h", bus.acc_rd_data[63:0], line_of(16'h1008) & 64'hFFFFFFFFFFFFFFFF);
    end
    tick();
    bus.acc_rd_en = '0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.acc_rd_data_valid, bus.acc_wr_done} !== 5'd0) begin
      n_bad++;
      $display("FAIL rd_after: got en=%b vld=%b done=%b, want 0", bus.mem_en,
               bus.acc_rd_data_valid, bus.acc_wr_done);
    end
    tick();
  endtask

  task automatic test_alternating_writes();
    int g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    do_reset();
    bus.acc_wr_en   = 2'b11;
    bus.acc_wr_addr = {16'h2100, 16'h2000};
    bus.acc_wr_data = {32'hBBBB0001, 32'hAAAA0000};
    for (int c = 0; c < 8; c++) begin
      g  = (c / 2) % 2;
      ea = (g == 0) ? 16'h2000 : 16'h2100;
      ed = (g == 0) ? 32'hAAAA0000 : 32'hBBBB0001;
      @(negedge clk);
      n_cmp++;
      if (c % 2 == 0) begin
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.acc_wr_done}
            !== {1'b1, 1'b1, ea, ed, 2'b00}) begin
          n_bad++;
          $display("FAIL wr_alt_issue c%0d: got en=%b wr=%b addr=%h data=%h done=%b, want 1 1 %h %h 00",
                   c, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.acc_wr_done, ea, ed);
        end
      end else begin
        if ({bus.mem_en, bus.acc_rd_data_valid, bus.acc_wr_done} !== {1'b0, 2'b00, 2'(1 << g)}) begin
          n_bad++;
          $display("FAIL wr_alt_done c%0d: got en=%b vld=%b done=%b, want 0 00 %b",
                   c, bus.mem_en, bus.acc_rd_data_valid, bus.acc_wr_done, 2'(1 << g));
        end
      end
      tick();
    end
    bus.acc_wr_en = '0;
  endtask

  task automatic test_starvation();
    do_reset();
    bus.cpu_en    = 1'b1;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = 16'h0042;
    bus.acc_rd_en = 2'b10;
    bus.acc_rd_addr[AW +: AW] = 16'h3000;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      n_cmp++;
      if (c < 16) begin
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.cpu_stall, bus.acc_rd_data_valid}
            !== {1'b1, 1'b0, 16'h0042, 1'b0, 2'b00}) begin
          n_bad++;
          $display("FAIL starve_cpu c%0d: got en=%b addr=%h stall=%b vld=%b, want 1 0042 0 00",
                   c, bus.mem_en, bus.mem_addr, bus.cpu_stall, bus.acc_rd_data_valid);
        end
      end else if (c == 16) begin
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.cpu_stall, bus.acc_rd_data_valid}
            !== {1'b1, 1'b0, 16'h3000, 1'b1, 2'b00}) begin
          n_bad++;
          $display("FAIL starve_force: got en=%b wr=%b addr=%h stall=%b vld=%b, want 1 0 3000 1 00",
                   bus.mem_en, bus.mem_wr, bus.mem_addr, bus.cpu_stall, bus.acc_rd_data_valid);
        end
      end else begin
        if ({bus.mem_en, bus.mem_addr, bus.cpu_stall, bus.acc_rd_data_valid, bus.acc_rd_data}
            !== {1'b1, 16'h0042, 1'b0, 2'b10, line_of(16'h3000)}) begin
          n_bad++;
          $display("FAIL starve_resp: got en=%b addr=%h stall=%b vld=%b, want 1 0042 0 10 with line of 3000",
                   bus.mem_en, bus.mem_addr, bus.cpu_stall, bus.acc_rd_data_valid);
        end
      end
      tick();
    end
    init_inputs();
  endtask

  task automatic test_rd_priority();
    do_reset();
    bus.acc_rd_en = 2'b01;
    bus.acc_wr_en = 2'b01;
    bus.acc_rd_addr[0 +: AW] = 16'h1100;
    bus.acc_wr_addr[0 +: AW] = 16'h1200;
    bus.acc_wr_data[0 +: DW] = 32'h0000ABCD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      case (c)
        0: if ({bus.mem_en, bus.mem_wr, bus.mem_addr} !== {1'b1, 1'b0, 16'h1100}) begin
             n_bad++;
             $display("FAIL prio_rd: got en=%b wr=%b addr=%h, want 1 0 1100", bus.mem_en, bus.mem_wr, bus.mem_addr);
           end
        1: if ({bus.acc_rd_data_valid, bus.acc_wr_done} !== 4'b0100) begin
             n_bad++;
             $display("FAIL prio_rd_ack: got vld=%b done=%b, want 01 00", bus.acc_rd_data_valid, bus.acc_wr_done);
           end
        2: if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 16'h1200, 32'h0000ABCD}) begin
             n_bad++;
             $display("FAIL prio_wr: got en=%b wr=%b addr=%h data=%h, want 1 1 1200 0000abcd",
                      bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
           end
        default: if ({bus.acc_rd_data_valid, bus.acc_wr_done} !== 4'b0001) begin
             n_bad++;
             $display("FAIL prio_wr_ack: got vld=%b done=%b, want 00 01", bus.acc_rd_data_valid, bus.acc_wr_done);
           end
      endcase
      tick();
      if (c == 1) bus.acc_rd_en = '0;
      if (c == 3) bus.acc_wr_en = '0;
    end
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    bus.acc_wr_en   = 2'b11;
    bus.acc_wr_addr = {16'h5100, 16'h5000};
    bus.acc_wr_data = {32'h00000006, 32'h00000005};
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 16'h5000, 32'h5}) begin
      n_bad++;
      $display("FAIL rstresp_issue: got en=%b wr=%b addr=%h data=%h, want 1 1 5000 5",
               bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.cpu_stall,
         bus.acc_rd_data_valid, bus.acc_wr_done} !== 54'd0) begin
      n_bad++;
      $display("FAIL rstresp_quiet: got en=%b addr=%h stall=%b vld=%b done=%b, want all 0",
               bus.mem_en, bus.mem_addr, bus.cpu_stall, bus.acc_rd_data_valid, bus.acc_wr_done);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.acc_wr_done} !== {1'b1, 1'b1, 16'h5000, 2'b00}) begin
      n_bad++;
      $display("FAIL rstresp_rearb: got en=%b wr=%b addr=%h done=%b, want 1 1 5000 00",
               bus.mem_en, bus.mem_wr, bus.mem_addr, bus.acc_wr_done);
    end
    tick();
    bus.acc_wr_en = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.acc_wr_done !== 2'b01) begin
      n_bad++;
      $display("FAIL rstresp_done: got done=%b want 01", bus.acc_wr_done);
    end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]    rd, wr, pend, e_vld, e_done;
    logic [N*AW-1:0] ra, wa;
    logic [N*DW-1:0] wd;
    logic [AW-1:0]   e_addr, m_addr;
    logic [DW-1:0]   e_wdata;
    bit              m_busy, m_op, e_en, e_wr, e_stall, stalled;
    int              m_idx, m_ptr, m_cnt, g;
    do_reset();
    m_busy = 0; m_op = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_addr = '0; stalled = 0;
    rd = '0; wr = '0; ra = '0; wa = '0; wd = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(31) == 0) begin rd[j] = 1'b0; wr[j] = 1'b0; end
        if (!rd[j] && $urandom_range(3) == 0) begin rd[j] = 1'b1; ra[j*AW +: AW] = AW'($urandom); end
        if (!wr[j] && $urandom_range(3) == 0) begin
          wr[j] = 1'b1;
          wa[j*AW +: AW] = AW'($urandom);
          wd[j*DW +: DW] = $urandom;
        end
      end
      if (!stalled) begin
        bus.cpu_en    = ($urandom_range(99) < ((cyc < 1000) ? 95 : 50));
        bus.cpu_wr    = 1'($urandom_range(1));
        bus.cpu_addr  = AW'($urandom);
        bus.cpu_wdata = $urandom;
      end
      bus.acc_rd_en = rd; bus.acc_rd_addr = ra;
      bus.acc_wr_en = wr; bus.acc_wr_addr = wa; bus.acc_wr_data = wd;
      @(negedge clk);
      pend = rd | wr;
      e_en = 0; e_wr = 0; e_stall = 0; e_vld = '0; e_done = '0; e_addr = '0; e_wdata = '0; g = -1;
      if (m_busy) begin
        if (m_op) e_done[m_idx] = 1'b1;
        else      e_vld[m_idx]  = 1'b1;
      end else if (pend != '0 && (!bus.cpu_en || m_cnt == LIM)) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        e_stall = (m_cnt == LIM);
        e_en    = 1;
        e_wr    = !rd[g];
        e_addr  = rd[g] ? ra[g*AW +: AW] : wa[g*AW +: AW];
        e_wdata = wd[g*DW +: DW];
      end
      if (!e_en && bus.cpu_en) begin
        e_en = 1; e_wr = bus.cpu_wr; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
      end
      n_cmp++;
      if ({bus.mem_en, bus.mem_wr, bus.cpu_stall, bus.acc_rd_data_valid, bus.acc_wr_done}
          !== {e_en, e_wr, e_stall, e_vld, e_done}) begin
        n_bad++;
        $display("FAIL rand_ctl cyc%0d: got en=%b wr=%b stall=%b vld=%b done=%b, want %b %b %b %b %b",
                 cyc, bus.mem_en, bus.mem_wr, bus.cpu_stall, bus.acc_rd_data_valid, bus.acc_wr_done,
                 e_en, e_wr, e_stall, e_vld, e_done);
      end
      if (e_en) begin
        n_cmp++;
        if (bus.mem_addr !== e_addr) begin
          n_bad++;
          $display("FAIL rand_addr cyc%0d: got %h want %h", cyc, bus.mem_addr, e_addr);
        end
      end
      if (e_en && e_wr) begin
        n_cmp++;
        if (bus.mem_wdata !== e_wdata) begin
          n_bad++;
          $display("FAIL rand_wdata cyc%0d: got %h want %h", cyc, bus.mem_wdata, e_wdata);
        end
      end
      if (e_vld != '0) begin
        n_cmp++;
        if (bus.acc_rd_data !== line_of(m_addr)) begin
          n_bad++;
          $display("FAIL rand_line cyc%0d: got %h want line of %h", cyc, bus.acc_rd_data[31:0], m_addr);
        end
      end
      stalled = e_stall;
      if (m_busy) begin
        m_busy = 0;
        rd = rd & ~e_vld;
        wr = wr & ~e_done;
        if (pend == '0) m_cnt = 0;
      end else if (g >= 0) begin
        m_busy = 1; m_idx = g; m_op = !rd[g]; m_addr = e_addr; m_ptr = (g + 1) % N; m_cnt = 0;
      end else if (pend == '0) begin
        m_cnt = 0;
      end else if (bus.cpu_en && m_cnt < LIM) begin
        m_cnt++;
      end
      tick();
    end
    init_inputs();
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_read();
    test_alternating_writes();
    test_starvation();
    test_rd_priority();
    test_reset_in_resp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/acc_mem_arbiter.md
ACC_MEM_ARBITER -- requirements
Module: acc_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_ACC, default 2, number of accelerator requesters.
REQ-002 SHALL have parameter STARVE_LIMIT, default 16, consecutive CPU-held cycles before an accelerator is forced through.
REQ-003 SHALL have parameters ADDR_SIZE = 16, WDATA_SIZE = 32 and LINE_SIZE = 512, all defaults.
REQ-004 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cpu_en  in  1; cpu_wr  in  1; cpu_addr  in  ADDR_SIZE; cpu_wdata  in  WDATA_SIZE: CPU data-memory access.
REQ-006 cpu_stall  out  1  CPU SHALL hold its access unchanged while high.
REQ-007 acc_rd_en  in  NUM_ACC; acc_rd_addr  in  NUM_ACC*ADDR_SIZE: per-accelerator line-read request, held until acknowledged.
REQ-008 acc_wr_en  in  NUM_ACC; acc_wr_addr  in  NUM_ACC*ADDR_SIZE; acc_wr_data  in  NUM_ACC*WDATA_SIZE: per-accelerator word write, held until acknowledged.
REQ-009 acc_rd_data_valid  out  NUM_ACC; acc_rd_data  out  LINE_SIZE; acc_wr_done  out  NUM_ACC: per-accelerator acknowledges, shared read bus.
REQ-010 mem_en, mem_wr  out  1; mem_addr  out  ADDR_SIZE; mem_wdata  out  WDATA_SIZE; mem_rdata  in  LINE_SIZE: single-port data memory, 1-cycle read latency.

Function
REQ-011 States: IDLE, RESP; IDLE -> RESP when an accelerator access is issued; RESP -> IDLE unconditionally.
REQ-012 In IDLE with cpu_en=1 and cpu_stall=0: mem_* SHALL pass CPU signals through that cycle; no accelerator issue.
REQ-013 In IDLE with cpu_en=0 (or cpu_stall=1) and any acc request pending: issue exactly one accelerator access that cycle.
REQ-014 Requester selection: round-robin over indices with acc_rd_en|acc_wr_en, search starting at pointer; pointer <= granted index + 1 (mod NUM_ACC) on issue.
REQ-015 Within one requester, read SHALL take precedence over write when both asserted.
REQ-016 Issue cycle: mem_en=1, mem_wr=op, mem_addr/mem_wdata from granted slice; granted index and op registered.
REQ-017 RESP cycle: exactly one one-cycle pulse, acc_rd_data_valid[idx] (read) or acc_wr_done[idx] (write); acc_rd_data = mem_rdata combinationally.
REQ-018 acc_rd_data SHALL be mem_rdata at all times; only the valid pulse qualifies it.
REQ-019 CPU access MAY occur in RESP cycle (mem free); CPU read data arrives the following cycle, no conflict with accelerator data.
REQ-020 Requester whose acknowledge pulsed in RESP SHALL NOT be regranted before the following IDLE cycle; a request seen in that IDLE is treated as new.
REQ-021 Starvation counter: increments in each IDLE cycle where cpu_en=1 and an acc request is pending; clears on any accelerator issue or when no request pending; saturates at STARVE_LIMIT.
REQ-022 When counter == STARVE_LIMIT in IDLE: cpu_stall=1 that cycle, accelerator issued per REQ-014; counter clears.
REQ-023 cpu_stall SHALL be high only in such forced IDLE cycles, never in RESP.
REQ-024 No requests and cpu_en=0: mem_en=0, all acknowledges 0, state IDLE.
REQ-025 Request deasserted before issue: dropped silently, no acknowledge.

Reset
REQ-026 rst_n low: state IDLE, pointer 0, counter 0, registered index/op 0; all outputs 0 except acc_rd_data (= mem_rdata).
REQ-027 Reset during RESP: pending acknowledge SHALL NOT be emitted; after release, held requests re-arbitrate from pointer 0.

Verification
REQ-028 Acc0 read 0x1008, cpu_en=0 -> cycle T mem_en=1 mem_wr=0 addr 0x1008; T+1 acc_rd_data_valid=01, acc_rd_data = line.
REQ-029 Acc0 and acc1 write continuously, pointer 0 -> grants 0,1,0,1 each 2 cycles apart; acc_wr_done alternates 01,10.
REQ-030 cpu_en=1 continuously, acc1 read pending -> 16 IDLE cycles CPU passthrough, 17th cycle cpu_stall=1 and acc1 issued, valid pulse next cycle.
REQ-031 Acc0 rd_en and wr_en both high -> read issued first, write issued in subsequent IDLE, total 4 cycles.
REQ-032 Acc0 write to 0x5000 data 0x5, rst_n asserted in RESP -> no acc_wr_done pulse; all outputs 0 during reset.
